// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one SRAM-like slave port between the instruction and data masters
// Grants address handshakes, records each accepted request's owner in an in-order ID FIFO
// and routes every returning data_ok/rdata beat back to that owner.
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate grants when both masters request
// (default build: fixed DATA priority).
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   inst_* / data_* (req..wdata)      master request side (in)
//   inst_* / data_* (addr_ok,data_ok,rdata)  master response side (out)
//   mem_req..mem_wdata                slave request side (out)
//   mem_addr_ok, mem_data_ok, mem_rdata  slave response side (in)
module sram_like_arbiter #(
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);
    localparam int PW = $clog2(OUTSTANDING);
    localparam logic DATA = 1'b1;
    logic [OUTSTANDING-1:0] id_q;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0] count;
    logic lock, locked_owner, owner, full, push, pop, head;
`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;
    always_comb owner = lock ? locked_owner : (inst_req & data_req) ? ~last_grant : data_req;
`else
    always_comb owner = lock ? locked_owner : data_req;
`endif
    // full blocks new requests even when a beat pops this cycle, keeping data_ok off the req path
    assign full = count == (PW+1)'(OUTSTANDING);
    assign mem_req = (owner == DATA ? data_req : inst_req) & ~full;
    assign mem_wr    = mem_req & (owner == DATA ? data_wr : inst_wr);
    assign mem_size  = mem_req ? (owner == DATA ? data_size  : inst_size)  : 2'b0;
    assign mem_wstrb = mem_req ? (owner == DATA ? data_wstrb : inst_wstrb) : 4'b0;
    assign mem_addr  = mem_req ? (owner == DATA ? data_addr  : inst_addr)  : 32'b0;
    assign mem_wdata = mem_req ? (owner == DATA ? data_wdata : inst_wdata) : 32'b0;
    assign push = mem_req & mem_addr_ok;
    assign inst_addr_ok = push & (owner != DATA);
    assign data_addr_ok = push & (owner == DATA);
    assign head = id_q[rd_ptr];
    // beats arriving with nothing outstanding are dropped
    assign pop = mem_data_ok & (count != '0);
    assign inst_data_ok = pop & (head != DATA);
    assign data_data_ok = pop & (head == DATA);
    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;
    always_ff @(posedge clk) if (push) id_q[wr_ptr] <= owner;
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            lock <= 1'b0;
            locked_owner <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
            // a pending request must be held by the same owner until accepted
            if (mem_req) begin
                lock <= ~mem_addr_ok;
                locked_owner <= owner;
            end
        end
    end
`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (reset) last_grant <= 1'b0;
        else if (push) last_grant <= owner;
    end
`endif
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: directed and randomized checks of sram_like_arbiter against a queue-based model
module tb_sram_like_arbiter;
    localparam int OUT = 2;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;
    logic [1:0] req;
    logic [1:0][70:0] pl;
    logic maok, mdok;
    logic [31:0] mrdata;
    logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic mem_req, mem_wr;
    logic [1:0] mem_size;
    logic [3:0] mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    int checks = 0, errors = 0;
    bit q[$];
    bit m_lock = 0, m_lo = 0, m_last = 0;
    logic [1:0] acc = '0;

    sram_like_arbiter #(.OUTSTANDING(OUT)) dut (
        .clk(clk), .reset(reset),
        .inst_req(req[0]), .inst_wr(pl[0][70]), .inst_size(pl[0][69:68]), .inst_wstrb(pl[0][67:64]),
        .inst_addr(pl[0][63:32]), .inst_wdata(pl[0][31:0]),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(req[1]), .data_wr(pl[1][70]), .data_size(pl[1][69:68]), .data_wstrb(pl[1][67:64]),
        .data_addr(pl[1][63:32]), .data_wdata(pl[1][31:0]),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(maok), .mem_data_ok(mdok), .mem_rdata(mrdata)
    );

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // called at a negedge: compare against the model, advance the model, move past the next posedge
    task automatic step();
        bit o, er, pop;
        logic [70:0] ep;
`ifdef ARB_ROUND_ROBIN_EN
        o = m_lock ? m_lo : (req == 2'b11) ? ~m_last : req[1];
`else
        o = m_lock ? m_lo : req[1];
`endif
        er = req[o] && q.size() != OUT;
        ep = er ? pl[o] : '0;
        pop = mdok && q.size() != 0;
        acc = '0;
        acc[o] = er & maok;
        chk("mem_req", 72'(mem_req), 72'(er));
        chk("payload", 72'({mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata}), 72'(ep));
        chk("inst_addr_ok", 72'(inst_addr_ok), 72'(acc[0]));
        chk("data_addr_ok", 72'(data_addr_ok), 72'(acc[1]));
        chk("inst_data_ok", 72'(inst_data_ok), 72'(pop ? q[0] == 0 : 1'b0));
        chk("data_data_ok", 72'(data_data_ok), 72'(pop ? q[0] == 1 : 1'b0));
        chk("inst_rdata", 72'(inst_rdata), 72'(mrdata));
        chk("data_rdata", 72'(data_rdata), 72'(mrdata));
        if (reset) begin
            q.delete();
            m_lock = 0;
            m_last = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (er && maok) begin
                q.push_back(o);
                m_lock = 0;
                m_last = o;
            end else if (er) begin
                m_lock = 1;
                m_lo = o;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        @(negedge clk);
        step();
    endtask

    initial begin
        reset = 1; req = '0; pl = '0; maok = 0; mdok = 0; mrdata = '0;
        repeat (2) @(posedge clk);
        #1;
        cyc();
        // fetch at reset vector, then its return
        reset = 0; req = 2'b01; maok = 1;
        pl[0] = {1'b0, 2'd2, 4'hf, 32'h1c000000, 32'h0};
        @(negedge clk);
        chk("t1_addr", 72'(mem_addr), 72'h1c000000);
        chk("t1_inst_addr_ok", 72'(inst_addr_ok), 72'd1);
        step();
        req = '0; maok = 0; mdok = 1; mrdata = 32'h02800c0c;
        @(negedge clk);
        chk("t1_inst_data_ok", 72'(inst_data_ok), 72'd1);
        chk("t1_data_data_ok", 72'(data_data_ok), 72'd0);
        chk("t1_rdata", 72'(inst_rdata), 72'h02800c0c);
        step();
        // both request: DATA first, then INST; returns in order
        mdok = 0; req = 2'b11; maok = 1;
        pl[1] = {1'b0, 2'd2, 4'hf, 32'h1c010000, 32'h0};
        @(negedge clk);
        chk("t2_data_first", 72'(mem_addr), 72'h1c010000);
        step();
        req = 2'b01;
        cyc();
        req = '0; mdok = 1; mrdata = 32'h11111111;
        cyc();
        mrdata = 32'h22222222;
        cyc();
        // DATA stalls, INST arrives later: lock holds DATA
        mdok = 0; req = 2'b10; maok = 0; pl[1] = {1'b1, 2'd2, 4'h3, 32'h1c020000, 32'hdeadbeef};
        cyc();
        req = 2'b11;
        repeat (2) cyc();
        maok = 1;
        cyc();
        req = 2'b01;
        cyc();
        req = '0; mdok = 1;
        repeat (2) cyc();
        // randomized traffic with protocol-compliant masters
        for (int n = 0; n < 3000; n++) begin
            for (int m = 0; m < 2; m++)
                if (!req[m] || acc[m]) begin
                    req[m] = $urandom_range(0, 3) != 0;
                    pl[m] = 71'({$urandom(), $urandom(), $urandom()});
                end
            maok = $urandom_range(0, 1) == 1;
            mdok = $urandom_range(0, 2) == 0;
            mrdata = $urandom();
            reset = $urandom_range(0, 49) == 0;
            cyc();
        end
        // fill, block the third, reset, stray beats dropped, then new request routed
        reset = 0; req = '0; maok = 0; mdok = 1;
        repeat (3) cyc();
        mdok = 0; maok = 1; req = 2'b01;
        cyc();
        req = 2'b10;
        cyc();
        req = 2'b01;
        @(negedge clk);
        chk("t4_full_blocks", 72'(mem_req), 72'd0);
        step();
        reset = 1; req = '0;
        cyc();
        reset = 0; mdok = 1;
        repeat (2) cyc();
        mdok = 0; req = 2'b10;
        cyc();
        req = '0; mdok = 1;
        @(negedge clk);
        chk("t6_routed", 72'(data_data_ok), 72'd1);
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
